// File: rtl/fw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fw_pkg                                                          |
// | Purpose  : Shared types and constants for the frame-buffer write path.    |
// |            Image size defaults are shared with the display-side reader.    |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fw_pkg;

  // Default image geometry, identical to the display-path reader window.
  localparam int c_img_w = 224;
  localparam int c_img_h = 224;

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_WRITE    = 2'd2
  } fw_state_t;

endpackage : fw_pkg
`default_nettype wire

// File: rtl/pix_pos_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pix_pos_counter                                                 |
// | Purpose  : Tracks the raster position (x, y) and RAM address of the next   |
// |            expected pixel. Addresses come from a running counter, so no    |
// |            multiplier is needed.                                           |
// | Ports    : i_clk, i_rst          clock, async active-high reset            |
// |            i_load_origin         pixel (0,0) written; move to the pixel    |
// |                                  after the origin                          |
// |            i_advance             current pixel written; step by one        |
// |            o_addr                RAM address of the current position       |
// |            o_eol                 current position is the last of its line  |
// |            o_eof                 current position is the last of the frame |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pix_pos_counter
  import fw_pkg::*;
#(
  parameter int IMG_W     = c_img_w,
  parameter int IMG_H     = c_img_h,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_origin,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_eol,
  output logic              o_eof
);

  localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  // y may step one past the last line after the final pixel; leave room for it.
  localparam int Y_W = $clog2(IMG_H + 1);

  localparam logic [X_W-1:0]    c_x_last = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]    c_y_last = Y_W'(IMG_H - 1);
  // Position right after the origin pixel: (1,0), or (0,1) for one-pixel lines.
  localparam logic [X_W-1:0]    c_x_org  = (IMG_W == 1) ? X_W'(0) : X_W'(1);
  localparam logic [Y_W-1:0]    c_y_org  = (IMG_W == 1) ? Y_W'(1) : Y_W'(0);
  localparam logic [ADDR_W-1:0] c_base   = ADDR_W'(BASE_ADDR);

  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= c_base;
    end else if (i_load_origin) begin
      r_x    <= c_x_org;
      r_y    <= c_y_org;
      r_addr <= c_base + ADDR_W'(1);
    end else if (i_advance) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (r_x == c_x_last) begin
        r_x <= '0;
        r_y <= r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  assign o_addr = r_addr;
  assign o_eol  = (r_x == c_x_last);
  assign o_eof  = (r_x == c_x_last) && (r_y == c_y_last);

endmodule : pix_pos_counter
`default_nettype wire

// File: rtl/frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : frame_writer                                                    |
// | Purpose  : Sink for the filtered pixel stream. Writes each accepted pixel  |
// |            into a single-port frame buffer at BASE_ADDR + y*IMG_W + x,     |
// |            checking start-of-frame / end-of-line framing.                  |
// | Ports    : i_clk, i_rst           clock, async active-high reset           |
// |            i_arm                  arm capture, clear error flags           |
// |            i_continuous           re-arm automatically after each frame    |
// |            i_valid/o_ready        pixel handshake                          |
// |            i_data, i_sof, i_eol   pixel value and framing markers          |
// |            o_we/o_addr/o_wdata    RAM write port (1-cycle latency)         |
// |            o_busy                 frame in progress                        |
// |            o_frame_done           pulse with the last pixel's write        |
// |            o_err_sof, o_err_eol   sticky framing errors                    |
// |            o_frame_cnt            completed frames, wraps at 256           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module frame_writer
  import fw_pkg::*;
#(
  parameter int IMG_W     = c_img_w,
  parameter int IMG_H     = c_img_h,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_arm,
  input  logic              i_continuous,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_sof,
  input  logic              i_eol,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err_sof,
  output logic              o_err_eol,
  output logic [7:0]        o_frame_cnt
);

  localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);

  fw_state_t         r_state;
  fw_state_t         w_next;

  logic              w_accept;
  logic              w_wr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_load;
  logic              w_adv;
  logic              w_set_sof;
  logic              w_set_eol;
  logic              w_done;

  logic [ADDR_W-1:0] w_cnt_addr;
  logic              w_cnt_eol;
  logic              w_cnt_eof;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_frame_done;
  logic              r_err_sof;
  logic              r_err_eol;
  logic [7:0]        r_frame_cnt;

  pix_pos_counter #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_pos (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_load_origin (w_load),
    .i_advance     (w_adv),
    .o_addr        (w_cnt_addr),
    .o_eol         (w_cnt_eol),
    .o_eof         (w_cnt_eof)
  );

  assign o_ready  = (r_state != S_DISARMED);
  assign w_accept = i_valid && o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_DISARMED;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_wr      = 1'b0;
    w_wr_addr = w_cnt_addr;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    w_set_sof = 1'b0;
    w_set_eol = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_DISARMED: begin
        if (i_arm) w_next = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        // Beats without sof are swallowed until the frame start shows up.
        if (w_accept && i_sof) begin
          w_wr      = 1'b1;
          w_wr_addr = c_base;
          w_load    = 1'b1;
          w_next    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_accept) begin
          if (i_sof) begin
            // A new frame start overrides the one in progress.
            w_set_sof = 1'b1;
            w_wr      = 1'b1;
            w_wr_addr = c_base;
            w_load    = 1'b1;
          end else if (i_eol != w_cnt_eol) begin
            // Line length disagrees with the marker: drop the frame.
            w_set_eol = 1'b1;
            w_next    = S_WAIT_SOF;
          end else begin
            w_wr  = 1'b1;
            w_adv = 1'b1;
            if (w_cnt_eof) begin
              w_done = 1'b1;
              w_next = i_continuous ? S_WAIT_SOF : S_DISARMED;
            end
          end
        end
      end
      default: w_next = S_DISARMED;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_frame_done <= 1'b0;
      r_err_sof    <= 1'b0;
      r_err_eol    <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_we         <= w_wr;
      r_frame_done <= w_done;
      if (w_wr) begin
        r_addr  <= w_wr_addr;
        r_wdata <= i_data;
      end
      if (w_done) r_frame_cnt <= r_frame_cnt + 8'd1;
      // A fresh error takes priority over a simultaneous arm.
      if (w_set_sof)  r_err_sof <= 1'b1;
      else if (i_arm) r_err_sof <= 1'b0;
      if (w_set_eol)  r_err_eol <= 1'b1;
      else if (i_arm) r_err_eol <= 1'b0;
    end
  end

  assign o_we         = r_we;
  assign o_addr       = r_addr;
  assign o_wdata      = r_wdata;
  assign o_busy       = (r_state == S_WRITE);
  assign o_frame_done = r_frame_done;
  assign o_err_sof    = r_err_sof;
  assign o_err_eol    = r_err_eol;
  assign o_frame_cnt  = r_frame_cnt;

endmodule : frame_writer
`default_nettype wire

// File: tb/tb_frame_writer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_frame_writer                                                 |
// | Purpose  : Self-checking bench for frame_writer. Expected RAM writes are   |
// |            queued as pixels are driven and compared as o_we appears.       |
// |            The frame height is reduced to keep runs short; the full        |
// |            224-pixel line width is kept.                                   |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_frame_writer;

  localparam int IMG_W     = 224;
  localparam int IMG_H     = 8;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 16;
  localparam int BASE_ADDR = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              done;
  } sb_entry_t;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_arm;
  logic              i_continuous;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              i_sof;
  logic              i_eol;
  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_wdata;
  logic              o_busy;
  logic              o_frame_done;
  logic              o_err_sof;
  logic              o_err_eol;
  logic [7:0]        o_frame_cnt;

  sb_entry_t sb[$];
  sb_entry_t r_exp;
  int        n_checks = 0;
  int        n_fail   = 0;
  int        exp_cnt  = 0;

  frame_writer #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_arm        (i_arm),
    .i_continuous (i_continuous),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .i_sof        (i_sof),
    .i_eol        (i_eol),
    .o_we         (o_we),
    .o_addr       (o_addr),
    .o_wdata      (o_wdata),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_err_sof    (o_err_sof),
    .o_err_eol    (o_err_eol),
    .o_frame_cnt  (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor: sampled on the falling edge, away from the active edge.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_we) begin
        if (sb.size() == 0) begin
          check_val("we_with_empty_sb", o_we, 1'b0);
        end else begin
          r_exp = sb.pop_front();
          check_val("wr_addr", o_addr, r_exp.addr);
          check_val("wr_data", o_wdata, r_exp.data);
          check_val("wr_done", o_frame_done, r_exp.done);
        end
      end else if (o_frame_done) begin
        check_val("done_without_we", o_frame_done, 1'b0);
      end
    end
  end

  // All driver tasks start and end at 1 ns after a rising edge.
  task automatic drive_beat(input logic [DATA_W-1:0] d, input bit sof, input bit eol,
                            input bit arm, input bit exp_ready);
    i_valid = 1'b1;
    i_data  = d;
    i_sof   = sof;
    i_eol   = eol;
    i_arm   = arm;
    check_val("ready", o_ready, exp_ready);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_eol   = 1'b0;
    i_arm   = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      i_data = DATA_W'($urandom);
      @(posedge i_clk); #1;
    end
  endtask

  task automatic arm_pulse();
    i_arm = 1'b1;
    @(posedge i_clk); #1;
    i_arm = 1'b0;
  endtask

  // Streams n correctly framed pixels starting at (x0,y0), wrapping into the
  // next frame after the last line. Each pixel's expected write is queued.
  task automatic send_pixels(input int x0, input int y0, input int n, input bit gaps);
    int x = x0;
    int y = y0;
    logic [DATA_W-1:0] d;
    sb_entry_t e;
    for (int k = 0; k < n; k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle(1);
      d      = DATA_W'(x + y);
      e.addr = ADDR_W'(BASE_ADDR + y * IMG_W + x);
      e.data = d;
      e.done = (x == IMG_W - 1) && (y == IMG_H - 1);
      if (e.done) exp_cnt++;
      sb.push_back(e);
      drive_beat(d, (x == 0) && (y == 0), x == IMG_W - 1, 1'b0, 1'b1);
      x++;
      if (x == IMG_W) begin
        x = 0;
        y++;
        if (y == IMG_H) y = 0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_we"},    o_we, 1'b0);
    check_val({tag, "_addr"},  o_addr, '0);
    check_val({tag, "_wdata"}, o_wdata, '0);
    check_val({tag, "_busy"},  o_busy, 1'b0);
    check_val({tag, "_done"},  o_frame_done, 1'b0);
    check_val({tag, "_esof"},  o_err_sof, 1'b0);
    check_val({tag, "_eeol"},  o_err_eol, 1'b0);
    check_val({tag, "_cnt"},   o_frame_cnt, 8'd0);
    check_val({tag, "_ready"}, o_ready, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sb_entry_t e;
    logic [DATA_W-1:0] d;

    i_rst = 1'b1; i_arm = 1'b0; i_continuous = 1'b0; i_valid = 1'b0;
    i_data = '0; i_sof = 1'b0; i_eol = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_outputs("reset");
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Disarmed: beats (even with sof) are refused.
    drive_beat(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_beat(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_beat(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    arm_pulse();
    check_val("armed_busy", o_busy, 1'b0);
    // Armed, waiting for sof: accepted but discarded.
    for (int i = 0; i < 3; i++) drive_beat(DATA_W'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);

    // Full frame, gap-free, single shot.
    send_pixels(0, 0, 5, 1'b0);
    check_val("busy_in_frame", o_busy, 1'b1);
    send_pixels(5, 0, IMG_W * IMG_H - 5, 1'b0);
    idle(2);
    check_val("f1_cnt", o_frame_cnt, exp_cnt);
    check_val("f1_ready", o_ready, 1'b0);
    check_val("f1_busy", o_busy, 1'b0);
    check_val("f1_sb_empty", sb.size(), 0);

    // Two back-to-back frames with random valid gaps, continuous mode.
    i_continuous = 1'b1;
    arm_pulse();
    send_pixels(0, 0, 2 * IMG_W * IMG_H, 1'b1);
    idle(2);
    check_val("f2_cnt", o_frame_cnt, exp_cnt);
    check_val("f2_ready", o_ready, 1'b1);
    check_val("f2_sb_empty", sb.size(), 0);
    i_continuous = 1'b0;

    // Early eol at x=100 of line 5 aborts the frame.
    send_pixels(0, 0, 5 * IMG_W + 100, 1'b0);
    drive_beat(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1);
    check_val("eol_err", o_err_eol, 1'b1);
    check_val("eol_sof_err", o_err_sof, 1'b0);
    check_val("eol_busy", o_busy, 1'b0);
    for (int i = 0; i < 3; i++) drive_beat(DATA_W'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    send_pixels(0, 0, IMG_W * IMG_H, 1'b0);
    idle(2);
    check_val("eol_sticky", o_err_eol, 1'b1);
    check_val("eol_cnt", o_frame_cnt, exp_cnt);
    arm_pulse();
    check_val("eol_cleared", o_err_eol, 1'b0);
    check_val("eol_rearm_ready", o_ready, 1'b1);

    // Mid-frame sof at (10,3) restarts at the base address.
    send_pixels(0, 0, 3 * IMG_W + 10, 1'b1);
    d = DATA_W'(10 + 3);
    e.addr = ADDR_W'(BASE_ADDR); e.data = d; e.done = 1'b0;
    sb.push_back(e);
    drive_beat(d, 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("sof_err", o_err_sof, 1'b1);
    send_pixels(1, 0, 4, 1'b0);
    // Second mid-frame sof coinciding with arm: the error must persist.
    d = 8'hC3;
    e.addr = ADDR_W'(BASE_ADDR); e.data = d; e.done = 1'b0;
    sb.push_back(e);
    drive_beat(d, 1'b1, 1'b0, 1'b1, 1'b1);
    check_val("sof_err_vs_arm", o_err_sof, 1'b1);
    send_pixels(1, 0, IMG_W * IMG_H - 1, 1'b0);
    idle(2);
    check_val("sof_cnt", o_frame_cnt, exp_cnt);
    check_val("sof_ready", o_ready, 1'b0);
    check_val("sof_sb_empty", sb.size(), 0);
    arm_pulse();
    check_val("sof_cleared", o_err_sof, 1'b0);

    // Asynchronous reset while a write is on the bus.
    send_pixels(0, 0, (IMG_H - 2) * IMG_W + 50, 1'b0);
    i_valid = 1'b1; i_data = 8'hA5; i_sof = 1'b0; i_eol = 1'b0;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    check_val("pre_rst_we", o_we, 1'b1);
    check_val("pre_rst_addr", o_addr, ADDR_W'(BASE_ADDR + (IMG_H - 2) * IMG_W + 50));
    i_rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    exp_cnt = 0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) drive_beat(DATA_W'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_val("post_rst_cnt", o_frame_cnt, exp_cnt);
    check_val("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_frame_writer
`default_nettype wire
